spawn_arbiter: RTL and testbench
================================

Name: spawn_arbiter

Overview:
- Shares the single write port of the bullet pool among N_EMIT danmaku emitters using round-robin arbitration.
- Active only while the game FSM reports PLAYING.
- Allocates the lowest free bullet slot and holds a valid/ready spawn handshake to the pool.
- Enforces a minimum gap between spawns and resets its fairness state whenever the game returns to INITIAL.

Parameters:
- N_EMIT, 4, number of emitter requesters (2..8).
- SLOT_BITS, 5, log2 of bullet pool size (pool = 2**SLOT_BITS slots).
- GAP_CYCLES, 8, idle cycles forced after each accepted spawn (0 allowed, max 255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- game_state  in  2  game FSM state: 0 INITIAL, 1 PLAYING, 2 OVER.
- req  in  N_EMIT  per-emitter spawn request, level, held until granted.
- slot_free  in  2**SLOT_BITS  pool free-slot bitmap, 1 = free.
- spawn_valid  out  1  spawn command valid to pool.
- spawn_ready  in  1  pool accepts the command.
- spawn_slot  out  SLOT_BITS  slot index to fill.
- spawn_src  out  log2(N_EMIT)  winning emitter index.
- grant  out  N_EMIT  one-hot, combinational: onehot(spawn_src) when spawn_valid & spawn_ready, else 0.
- spawn_cnt  out  16  accepted spawns since INITIAL (see Optional Feature).

Behaviour:
- Reset values: state IDLE; spawn_valid=0; spawn_slot=0; spawn_src=0; rr pointer=0; gap counter=0; spawn_cnt=0.
- States are IDLE, ISSUE and GAP.
- IDLE: if game_state==1 & |req & |slot_free at edge t:
  - register the winner, searching from rr pointer upward with wrap;
  - register the lowest-index set bit of slot_free;
  - enter ISSUE, so spawn_valid=1 at t+1.
- IDLE otherwise: remain in IDLE.
- ISSUE:
  - spawn_valid, spawn_slot and spawn_src stay stable until handshake.
  - On spawn_valid & spawn_ready, the grant pulse occurs that cycle.
  - rr pointer becomes (winner+1) mod N_EMIT.
  - If GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES; else go to IDLE.
- GAP: decrement each cycle; at counter==1 go to IDLE. Exactly GAP_CYCLES cycles spent in GAP.
- Requests are ignored in ISSUE and GAP. Request drops before grant are not tracked; the registered winner is still issued.
- game_state != 1 while in ISSUE or GAP:
  - abort next edge: state IDLE, spawn_valid=0, gap counter cleared, no grant;
  - a handshake in that same cycle still counts as accepted.
- game_state==0 (INITIAL) in any state also clears the rr pointer and spawn_cnt.
- game_state==2 (OVER) freezes rr pointer and spawn_cnt.
- No free slot (slot_free==0): no arbitration; requests wait. slot_free is sampled only in IDLE; the pool must not reclaim an issued slot before acceptance.
- Round-robin fairness: with all requests continuously high, winners cycle 0,1,...,N_EMIT-1,0.
- spawn_cnt saturates at 16'hFFFF.
- Asynchronous reset mid-handshake drops spawn_valid immediately.

Optional Feature:
- Macro SPAWN_ARB_STATS_EN.
- Defined: spawn_cnt counts accepted handshakes with the clear/freeze/saturate rules above.
- Undefined: no counter register; spawn_cnt tied to 16'd0.

Decomposition:
- Shared package holds:
  - game state codes GAME_INITIAL=2'd0, GAME_PLAYING=2'd1, GAME_OVER=2'd2, reused from the game FSM;
  - arbiter state encodings.
- Natural sub-module: rr_pick, a combinational rotating priority encoder (req, pointer -> index, found). It is reused for the lowest-free-slot search with pointer fixed at 0.

Test Plan:
- Reset release, game_state=1, req=4'b0100, slot_free=1 at bit 3 only -> spawn_valid next cycle with spawn_src=2, spawn_slot=3; spawn_ready=1 -> grant=4'b0100 that cycle.
- req=4'b1111 held, spawn_ready always 1, GAP_CYCLES=8 -> sources 0,1,2,3,0 in order, successive grants exactly 10 cycles apart.
- game_state=0 then req=4'b0001 -> no spawn_valid; switch to 1 -> spawn issues. Leave PLAYING during ISSUE with spawn_ready=0 -> spawn_valid low next cycle, no grant.
- slot_free=0 with req=4'b0010 for 20 cycles -> no spawn_valid; set slot_free bit 7 -> spawn_slot=7, spawn_src=1.
- spawn_ready low for 5 cycles during ISSUE -> spawn_valid, spawn_slot and spawn_src stable for all 5; single grant on accept.
- With SPAWN_ARB_STATS_EN: 3 accepts -> spawn_cnt=3; game_state=2 holds 3; game_state=0 clears to 0. Without the macro, spawn_cnt stays 0.

Source files
------------

// File: rtl/spawn_arbiter_pkg.sv
// Shared definitions for the bullet-spawn arbiter: game FSM state codes
// (same encoding the game FSM drives) and the arbiter's own state encoding.
package spawn_arbiter_pkg;

  localparam logic [1:0] GAME_INITIAL = 2'd0;
  localparam logic [1:0] GAME_PLAYING = 2'd1;
  localparam logic [1:0] GAME_OVER    = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/spawn_arbiter_if.sv
// Spawn command channel between the arbiter (master) and the bullet pool (slave).
interface spawn_arbiter_if #(
  parameter int N_EMIT    = 4,
  parameter int SLOT_BITS = 5
);
  localparam int SRC_W = $clog2(N_EMIT);

  logic                 spawn_valid;
  logic                 spawn_ready;
  logic [SLOT_BITS-1:0] spawn_slot;
  logic [SRC_W-1:0]     spawn_src;
  logic [N_EMIT-1:0]    grant;

  modport master (output spawn_valid, spawn_slot, spawn_src, grant, input spawn_ready);
  modport slave  (input spawn_valid, spawn_slot, spawn_src, grant, output spawn_ready);

endinterface

// File: rtl/spawn_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set bit of req_i at or above
// ptr_i, wrapping around. With ptr_i tied to 0 it is a plain lowest-set-bit finder.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] pos;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_o = '0;
    pos   = '0;
    // Walk from the farthest offset down so the nearest requester wins last.
    for (int k = N - 1; k >= 0; k--) begin
      pos = IW'((int'(ptr_i) + k) % N);
      if (req_i[pos]) idx_o = pos;
    end
  end

  assign found_o = |req_i;

endmodule

// File: rtl/spawn_arbiter.sv
// Round-robin arbiter sharing the bullet pool write port among N_EMIT emitters.
// Optional spawn counter enabled by defining SPAWN_ARB_STATS_EN.
module spawn_arbiter
  import spawn_arbiter_pkg::*;
#(
  parameter int N_EMIT     = 4,
  parameter int SLOT_BITS  = 5,
  parameter int GAP_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              game_state,
  input  logic [N_EMIT-1:0]       req,
  input  logic [2**SLOT_BITS-1:0] slot_free,
  spawn_arbiter_if.master         spawn_bus,
  output logic [15:0]             spawn_cnt
);

  localparam int         SRC_W    = $clog2(N_EMIT);
  localparam int         POOL     = 2**SLOT_BITS;
  localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);

  arb_state_e           state_q;
  logic                 valid_q;
  logic [SLOT_BITS-1:0] slot_q;
  logic [SRC_W-1:0]     src_q, rr_q, rr_d;
  logic [7:0]           gap_q;

  logic [SRC_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [SLOT_BITS-1:0] slot_idx;
  logic                 slot_found;
  logic                 playing, accept;

  rr_pick #(.N(N_EMIT)) u_req_pick (
    .req_i(req), .ptr_i(rr_q), .idx_o(pick_idx), .found_o(pick_found)
  );

  rr_pick #(.N(POOL)) u_slot_pick (
    .req_i(slot_free), .ptr_i('0), .idx_o(slot_idx), .found_o(slot_found)
  );

  assign playing = (game_state == GAME_PLAYING);
  assign accept  = valid_q & spawn_bus.spawn_ready;
  assign rr_d    = (src_q == SRC_W'(N_EMIT - 1)) ? '0 : src_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      valid_q <= 1'b0;
      slot_q  <= '0;
      src_q   <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (playing && pick_found && slot_found) begin
            src_q   <= pick_idx;
            slot_q  <= slot_idx;
            valid_q <= 1'b1;
            state_q <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (!playing) begin
            valid_q <= 1'b0;
            state_q <= ARB_IDLE;
          end else if (accept) begin
            valid_q <= 1'b0;
            if (GAP_CYCLES > 0) begin
              gap_q   <= GAP_INIT;
              state_q <= ARB_GAP;
            end else begin
              state_q <= ARB_IDLE;
            end
          end
        end
        ARB_GAP: begin
          if (!playing || gap_q == 8'd1) begin
            gap_q   <= '0;
            state_q <= ARB_IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: begin
          valid_q <= 1'b0;
          gap_q   <= '0;
          state_q <= ARB_IDLE;
        end
      endcase

      // Fairness pointer: cleared at INITIAL, frozen at OVER.
      if (game_state == GAME_INITIAL) rr_q <= '0;
      else if (accept && game_state != GAME_OVER) rr_q <= rr_d;
    end
  end

  assign spawn_bus.spawn_valid = valid_q;
  assign spawn_bus.spawn_slot  = slot_q;
  assign spawn_bus.spawn_src   = src_q;
  assign spawn_bus.grant       = accept ? ({{(N_EMIT-1){1'b0}}, 1'b1} << src_q) : '0;

`ifdef SPAWN_ARB_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (game_state == GAME_INITIAL) begin
      cnt_q <= '0;
    end else if (accept && game_state != GAME_OVER && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign spawn_cnt = cnt_q;
`else
  assign spawn_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_spawn_arbiter.sv
// Self-checking bench for spawn_arbiter: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural reference model.
module tb_spawn_arbiter;

  localparam int N    = 4;
  localparam int SB   = 5;
  localparam int GAP  = 8;
  localparam int POOL = 32;
`ifdef SPAWN_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      game_state;
  logic [N-1:0]    req;
  logic [POOL-1:0] slot_free;
  logic [15:0]     spawn_cnt;

  spawn_arbiter_if #(.N_EMIT(N), .SLOT_BITS(SB)) sif ();

  spawn_arbiter #(.N_EMIT(N), .SLOT_BITS(SB), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .game_state(game_state), .req(req),
    .slot_free(slot_free), .spawn_bus(sif), .spawn_cnt(spawn_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grant_cycles[$];
  int grant_srcs[$];

  // Reference model: a pending command, remaining gap cycles, fairness pointer, count.
  bit m_valid;
  int m_src, m_slot, m_gap, m_rr, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_src = 0; m_slot = 0; m_gap = 0; m_rr = 0; m_cnt = 0;
  endtask

  task automatic model_advance();
    bit acc;
    int gs;
    bit got;
    gs  = int'(game_state);
    acc = m_valid && sif.spawn_ready;
    if (m_valid) begin
      if (gs != 1) m_valid = 0;
      else if (acc) begin
        m_valid = 0;
        m_gap   = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap = (gs != 1) ? 0 : m_gap - 1;
    end else if (gs == 1 && req != 0 && slot_free != 0) begin
      got = 0;
      for (int k = 0; k < N; k++)
        if (!got && req[(m_rr + k) % N]) begin m_src = (m_rr + k) % N; got = 1; end
      got = 0;
      for (int i = 0; i < POOL; i++)
        if (!got && slot_free[i]) begin m_slot = i; got = 1; end
      m_valid = 1;
    end
    if (gs == 0) begin
      m_rr = 0; m_cnt = 0;
    end else if (acc && gs != 2) begin
      m_rr = (m_src + 1) % N;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic compare();
    check("valid", sif.spawn_valid, m_valid);
    if (m_valid) begin
      check("src", sif.spawn_src, m_src);
      check("slot", sif.spawn_slot, m_slot);
    end
    check("grant", sif.grant, (m_valid && sif.spawn_ready) ? (32'd1 << m_src) : 32'd0);
    check("cnt", spawn_cnt, STATS ? m_cnt : 0);
  endtask

  // Called at a falling edge with inputs already applied.
  task automatic cycle();
    #1;
    compare();
    if (sif.grant != '0) begin
      grant_cycles.push_back(cyc);
      grant_srcs.push_back(int'(sif.spawn_src));
    end
    model_advance();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int n;
    game_state = 2'd0; req = '0; slot_free = '0; sif.spawn_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", sif.spawn_valid, 0);
    check("rst_slot", sif.spawn_slot, 0);
    check("rst_src", sif.spawn_src, 0);
    check("rst_cnt", spawn_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, single free slot.
    game_state = 2'd1; req = 4'b0100; slot_free = 32'h8;
    cycle();
    check("t1_valid", sif.spawn_valid, 1);
    check("t1_src", sif.spawn_src, 2);
    check("t1_slot", sif.spawn_slot, 3);
    sif.spawn_ready = 1'b1;
    #1 check("t1_grant", sif.grant, 4'b0100);
    cycle();
    req = '0;

    // Round-robin order and grant spacing with all requesters active.
    game_state = 2'd0; req = 4'b1111; slot_free = '1;
    cycle();
    game_state = 2'd1;
    grant_cycles.delete(); grant_srcs.delete();
    repeat (45) cycle();
    check("rr_num", grant_srcs.size() >= 5, 1);
    if (grant_srcs.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("rr_src", grant_srcs[i], i % N);
      for (int i = 1; i < 5; i++) check("rr_gap", grant_cycles[i] - grant_cycles[i-1], GAP + 2);
    end

    // Gated by game state; abort from ISSUE without a handshake.
    game_state = 2'd0; req = 4'b0001; sif.spawn_ready = 1'b0;
    repeat (3) cycle();
    check("t3_idle", sif.spawn_valid, 0);
    game_state = 2'd1;
    cycle();
    check("t3_issue", sif.spawn_valid, 1);
    game_state = 2'd2;
    #1 check("t3_nogrant", sif.grant, 0);
    cycle();
    check("t3_abort", sif.spawn_valid, 0);

    // No free slot: requests wait.
    game_state = 2'd1; slot_free = '0; req = 4'b0010;
    repeat (20) cycle();
    check("t4_wait", sif.spawn_valid, 0);
    slot_free = 32'h80;
    cycle();
    check("t4_valid", sif.spawn_valid, 1);
    check("t4_slot", sif.spawn_slot, 7);
    check("t4_src", sif.spawn_src, 1);

    // Backpressure: command stable until accepted, single grant.
    grant_srcs.delete();
    repeat (5) begin
      check("t5_valid", sif.spawn_valid, 1);
      check("t5_slot", sif.spawn_slot, 7);
      check("t5_src", sif.spawn_src, 1);
      cycle();
    end
    sif.spawn_ready = 1'b1;
    cycle();
    req = '0; sif.spawn_ready = 1'b0;
    repeat (3) cycle();
    check("t5_grants", grant_srcs.size(), 1);

    // Spawn counter: count, freeze at OVER, clear at INITIAL.
    game_state = 2'd0;
    cycle();
    check("t6_clr0", spawn_cnt, 0);
    game_state = 2'd1; req = 4'b0001; sif.spawn_ready = 1'b1; slot_free = '1;
    grant_srcs.delete();
    n = 0;
    while (grant_srcs.size() < 3 && n < 60) begin cycle(); n++; end
    check("t6_accepts", grant_srcs.size(), 3);
    req = '0;
    check("t6_cnt", spawn_cnt, STATS ? 3 : 0);
    game_state = 2'd2;
    repeat (3) cycle();
    check("t6_freeze", spawn_cnt, STATS ? 3 : 0);
    game_state = 2'd0;
    cycle();
    check("t6_clear", spawn_cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      n = $urandom_range(0, 39);
      game_state = (n == 0) ? 2'd0 : (n == 1) ? 2'd2 : 2'd1;
      req = N'($urandom);
      n = $urandom_range(0, 9);
      slot_free = (n < 2) ? '0 : (n < 5) ? (32'd1 << $urandom_range(0, POOL-1)) : $urandom;
      sif.spawn_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end

    // Asynchronous reset during a pending command.
    game_state = 2'd0; req = 4'b0001; slot_free = '1; sif.spawn_ready = 1'b0;
    cycle();
    game_state = 2'd1;
    cycle();
    check("t8_valid", sif.spawn_valid, 1);
    rst_n = 1'b0;
    #1 check("t8_async", sif.spawn_valid, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
